// File: rtl/beat_sequencer.sv
// W1/W2/W3 machine-cycle beat generator with run/halt/step sequencing,
// st0 phase register and completed-machine-cycle counter.
module beat_sequencer #(
  parameter int CNT_W      = 16,
  parameter bit AUTO_START = 1'b0
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             start,
  input  logic             step_mode,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  input  logic             sst0,
  input  logic             st0_clr,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             st0,
  output logic             running,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  typedef enum logic [1:0] {B_W1, B_W2, B_W3} beat_e;

  // In RUN beat_q is the current beat; in IDLE it holds the resume beat.
  state_e             state_q, state_d;
  beat_e              beat_q, beat_d, nxt_beat;
  logic               start_q, start_d;
  logic               st0_q, st0_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic               running_q, running_d;
  logic               start_edge, end_cycle;

  function automatic beat_e next_beat(input beat_e cur, input logic sh, input logic lg);
    beat_e nb;
    case (cur)
      B_W1:    nb = sh ? B_W1 : B_W2;
      B_W2:    nb = lg ? B_W3 : B_W1;
      default: nb = B_W1;
    endcase
    return nb;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_incr(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    st0_d      = st0_q;
    start_d    = start;
    start_edge = start & ~start_q;
    nxt_beat   = next_beat(beat_q, short, long);
    end_cycle  = (nxt_beat == B_W1);

    if (sst0)
      st0_d = 1'b1;
    else if (st0_clr)
      st0_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge)
          state_d = ST_RUN;
      end
      default: begin
        beat_d = nxt_beat;
        if (end_cycle)
          cnt_d = cnt_incr(cnt_q);
        if (stop || (step_mode && end_cycle))
          state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
    w1_d      = running_d && (beat_d == B_W1);
    w2_d      = running_d && (beat_d == B_W2);
    w3_d      = running_d && (beat_d == B_W3);
  end

  always_ff @(posedge t3) begin
    if (clr) begin
      state_q   <= AUTO_START ? ST_RUN : ST_IDLE;
      beat_q    <= B_W1;
      start_q   <= 1'b0;
      st0_q     <= 1'b0;
      cnt_q     <= '0;
      w1_q      <= AUTO_START;
      w2_q      <= 1'b0;
      w3_q      <= 1'b0;
      running_q <= AUTO_START;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      start_q   <= start_d;
      st0_q     <= st0_d;
      cnt_q     <= cnt_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      w3_q      <= w3_d;
      running_q <= running_d;
    end
  end

  assign w1      = w1_q;
  assign w2      = w2_q;
  assign w3      = w3_q;
  assign st0     = st0_q;
  assign running = running_q;
  assign cyc_cnt = cnt_q;

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Generates the W1/W2/W3 machine-cycle beat signals that the hardwired instruction controller consumes.
- Honours the controller's `short`, `long` and `stop` requests, and provides run/halt sequencing from the panel start key, including single-cycle stepping.
- Owns the `st0` phase register and a completed-machine-cycle counter for debug display.
- Sits between the front panel and the hardwired controller, clocked on t3.

Parameters:
- CNT_W, 16, width of the completed-machine-cycle counter `cyc_cnt`.
- AUTO_START, 0, when 1 the block leaves reset directly in RUN at W1 instead of IDLE.

Ports:
- t3  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset; synchronous, active-high.
- start  input  1  panel start key, level; only its rising edge acts.
- step_mode  input  1  1 = halt after each completed machine cycle.
- short  input  1  from controller; valid only during W1.
- long  input  1  from controller; valid only during W2.
- stop  input  1  from controller; halt after the current beat.
- sst0  input  1  from controller; set `st0` at end of the current beat.
- st0_clr  input  1  from controller; clear `st0` at end of the current beat.
- w1  output  1  beat 1, registered.
- w2  output  1  beat 2, registered.
- w3  output  1  beat 3, registered.
- st0  output  1  phase register.
- running  output  1  1 while the sequencer is in RUN.
- cyc_cnt  output  CNT_W  count of completed machine cycles; wraps.

Behaviour:
- Reset (clr=1 at an edge), regardless of current state:
  - `w1`=`w2`=`w3`=0, `st0`=0, `cyc_cnt`=0, resume beat = W1, `start_q`=0.
  - If AUTO_START=0: `running`=0, state IDLE.
  - If AUTO_START=1: `running`=1, `w1`=1, state RUN.
- Start edge: `start_q` registers `start` every cycle. A start edge is start=1 and start_q=0 at an edge.
- States:
  - IDLE: all beats 0, `running`=0.
  - RUN: exactly one of w1/w2/w3 is 1.
- IDLE -> RUN: on a start edge. The stored resume beat is asserted after that same edge, i.e. 1-cycle latency from the edge.
- RUN, next-beat rules, evaluated at each edge from the current beat:
  - W1: short=1 -> W1; otherwise -> W2.
  - W2: long=1 -> W3; otherwise -> W1.
  - W3: -> W1.
  - `short` outside W1 and `long` outside W2 are ignored.
- End of machine cycle: any transition whose next beat is W1. On each such transition `cyc_cnt` increments by 1, wrapping from 2^CNT_W-1 to 0.
- RUN -> IDLE, stop: stop=1 at an edge in any beat. The next beat, computed by the rules above, is stored as the resume beat, all w go 0, and `running`=0. `cyc_cnt` still increments if the computed next beat is W1.
- RUN -> IDLE, step mode: step_mode=1 and an end of machine cycle occurs. The resume beat is W1.
- Start edges while in RUN are ignored and discarded, not queued.
- Simultaneous events:
  - stop and start edge in the same RUN cycle: stop wins and the start edge is discarded.
  - stop and step-halt coincide: identical result.
- `st0` update, at every non-reset edge, in any state:
  - sst0=1 -> `st0`=1.
  - else st0_clr=1 and `st0`=1 -> `st0`=0.
  - else hold.
  - sst0 has priority over st0_clr.
- Inputs are sampled only at the t3 edge. All outputs are registered, with no combinational path from input to output.
- Toggling step_mode mid-cycle takes effect at the next end of machine cycle.

Test Plan:
- Reset and start: clr=1 for 2 cycles, then start 0->1. Required: all outputs 0 after reset; w1=1 and running=1 one cycle after the edge; beats then W1,W2,W1,W2; cyc_cnt=2 after 4 beats.
- Short and long: short=1 in W1 gives W1,W1; long=1 in W2 gives W1,W2,W3,W1 and cyc_cnt +1; long=1 in W1 and short=1 in W2 have no effect.
- Stop and resume: stop=1 during W2 with long=1. Required: running=0, all w=0, cyc_cnt unchanged; the next start edge resumes at W3, then W1 with cyc_cnt +1.
- Step mode: step_mode=1 with long=1 on every W2. Required: each start edge yields exactly W1,W2,W3 then halt, cyc_cnt +1 per edge; holding start high yields no second cycle.
- st0 priority: sst0=1 with st0_clr=1 gives st0=1; st0_clr alone then gives st0=0; clr=1 mid-W2 gives every output 0 and resume beat W1.
- Wrap: with CNT_W=4, run 16 machine cycles from cyc_cnt=0. Required: cyc_cnt=0; stop and start edge in the same cycle gives halt with no restart.
